pipe_hazard_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage core pipeline (IF, ID, EX, MEM, WB). It tracks a valid bit per stage register, detects load-use hazards, and holds EX for multi-cycle mul/div. It squashes younger instructions on a taken branch and drains the pipe on a trap. Its enable outputs drive the per-stage pipeline registers, and its valid outputs qualify each stage's writes.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_ld_use_cmp.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard sequencer
// and the helpers built around it.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MDIV  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int REGW_DEF = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_ld_use_cmp.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register a valid EX load is about to write. x0 never hazards.
module ld_use_cmp
  import pipe_pkg::*;
#(
  parameter int REGW = REGW_DEF
) (
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic [REGW-1:0] rd,
  input  logic            ex_load,
  input  logic            ex_valid,
  input  logic            id_valid,
  output logic            hazard
);

  logic rd_live;
  logic src_match;

  assign rd_live   = ex_valid & ex_load & (rd != '0);
  assign src_match = (use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd));
  assign hazard    = rd_live & id_valid & src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline: tracks stage valid
// bits, inserts load-use bubbles, holds EX for mul/div and drains on a trap.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int REGW       = REGW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fetch_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_load,
  input  logic            ex_muldiv,
  input  logic            br_taken,
  input  logic            trap,
  output logic            en_ifid,
  output logic            en_idex,
  output logic            en_exmem,
  output logic            en_memwb,
  output logic            v_id,
  output logic            v_ex,
  output logic            v_mem,
  output logic            v_wb,
  output logic            redirect,
  output logic            trap_done,
  output logic            busy
);

  localparam int CNTW = $clog2(MULDIV_LAT);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MULDIV_LAT - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  state_e                   state;
  logic [CNTW-1:0]          cnt;
  logic [STAGE_WB:STAGE_ID] vld;
  logic [STAGE_WB:STAGE_ID] vld_nxt;

  logic hazard;
  logic trap_ev;
  logic md_ev;
  logic br_ev;
  logic lu_ev;
  logic md_done;
  logic advance;
  logic drained;

  ld_use_cmp #(.REGW(REGW)) u_ld_use (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .use_rs1  (id_use_rs1),
    .use_rs2  (id_use_rs2),
    .rd       (ex_rd),
    .ex_load  (ex_load),
    .ex_valid (vld[STAGE_EX]),
    .id_valid (vld[STAGE_ID]),
    .hazard   (hazard)
  );

  assign drained = ~vld[STAGE_MEM] & ~vld[STAGE_WB];

  // Event decode, strictly prioritised trap > muldiv > branch > load-use.
  always_comb begin
    trap_ev = 1'b0;
    md_ev   = 1'b0;
    br_ev   = 1'b0;
    lu_ev   = 1'b0;
    md_done = 1'b0;
    case (state)
      RUN: begin
        trap_ev = vld[STAGE_EX] & trap;
        md_ev   = vld[STAGE_EX] & ex_muldiv & ~trap_ev;
        br_ev   = vld[STAGE_EX] & br_taken & ~trap_ev & ~md_ev;
        lu_ev   = hazard & ~trap_ev & ~md_ev & ~br_ev;
      end
      MDIV: begin
        trap_ev = vld[STAGE_EX] & trap;
        md_done = (cnt == '0) & ~trap_ev;
      end
      default: begin
      end
    endcase
  end

  assign advance = ((state == RUN) & ~trap_ev & ~md_ev & ~br_ev & ~lu_ev) | md_done;

  always_comb begin
    en_ifid  = 1'b1;
    en_idex  = 1'b1;
    en_exmem = 1'b1;
    en_memwb = 1'b1;
    case (state)
      RUN: begin
        if (trap_ev | md_ev) begin
          en_ifid = 1'b0;
          en_idex = 1'b0;
        end else if (lu_ev) begin
          en_ifid = 1'b0;
        end
      end
      MDIV: begin
        if (!md_done) begin
          en_ifid = 1'b0;
          en_idex = 1'b0;
        end
      end
      default: begin
        en_ifid = 1'b0;
        en_idex = 1'b0;
      end
    endcase
  end

  // WB always inherits MEM; the younger stages depend on which event won.
  always_comb begin
    vld_nxt           = vld;
    vld_nxt[STAGE_WB] = vld[STAGE_MEM];
    if (advance) begin
      vld_nxt[STAGE_MEM] = vld[STAGE_EX];
      vld_nxt[STAGE_EX]  = vld[STAGE_ID];
      vld_nxt[STAGE_ID]  = fetch_valid;
    end else if (trap_ev || state == DRAIN) begin
      vld_nxt[STAGE_MEM] = 1'b0;
      vld_nxt[STAGE_EX]  = 1'b0;
      vld_nxt[STAGE_ID]  = 1'b0;
    end else if (br_ev) begin
      vld_nxt[STAGE_MEM] = vld[STAGE_EX];
      vld_nxt[STAGE_EX]  = 1'b0;
      vld_nxt[STAGE_ID]  = 1'b0;
    end else if (lu_ev) begin
      vld_nxt[STAGE_MEM] = vld[STAGE_EX];
      vld_nxt[STAGE_EX]  = 1'b0;
    end else begin
      vld_nxt[STAGE_MEM] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      cnt       <= '0;
      vld       <= '0;
      redirect  <= 1'b0;
      trap_done <= 1'b0;
    end else begin
      vld       <= vld_nxt;
      redirect  <= br_ev;
      trap_done <= (state == DRAIN) & drained;
      case (state)
        RUN: begin
          if (trap_ev) begin
            state <= DRAIN;
            cnt   <= '0;
          end else if (md_ev) begin
            state <= MDIV;
            cnt   <= CNT_LOAD;
          end
        end
        MDIV: begin
          if (trap_ev) begin
            state <= DRAIN;
            cnt   <= '0;
          end else if (md_done) begin
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign v_id  = vld[STAGE_ID];
  assign v_ex  = vld[STAGE_EX];
  assign v_mem = vld[STAGE_MEM];
  assign v_wb  = vld[STAGE_WB];
  assign busy  = (state != RUN);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus a
// random stream, all compared against an instruction-tag pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
  localparam int RW  = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          fetch_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] ex_rd;
  logic          ex_load;
  logic          ex_muldiv;
  logic          br_taken;
  logic          trap;
  logic          en_ifid;
  logic          en_idex;
  logic          en_exmem;
  logic          en_memwb;
  logic          v_id;
  logic          v_ex;
  logic          v_mem;
  logic          v_wb;
  logic          redirect;
  logic          trap_done;
  logic          busy;

  pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .REGW(RW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_valid (fetch_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_load     (ex_load),
    .ex_muldiv   (ex_muldiv),
    .br_taken    (br_taken),
    .trap        (trap),
    .en_ifid     (en_ifid),
    .en_idex     (en_idex),
    .en_exmem    (en_exmem),
    .en_memwb    (en_memwb),
    .v_id        (v_id),
    .v_ex        (v_ex),
    .v_mem       (v_mem),
    .v_wb        (v_wb),
    .redirect    (redirect),
    .trap_done   (trap_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  // Model: pipe[1..4] = ID, EX, MEM, WB holding an instruction tag (0 = empty).
  int pipe [1:4];
  int hold_left;
  bit draining;
  bit exp_redirect;
  bit exp_trap_done;
  int next_tag;
  int stall_seen;

  int busy_cycles;
  int redirect_pulses;
  int entry_at;
  int done_at;
  int done_pulses;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit fv, input int rs1, input int rs2, input bit u1,
                               input bit u2, input int rd, input bit ld, input bit md,
                               input bit br, input bit tr);
    fetch_valid = fv;
    id_rs1      = RW'(rs1);
    id_rs2      = RW'(rs2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    ex_rd       = RW'(rd);
    ex_load     = ld;
    ex_muldiv   = md;
    br_taken    = br;
    trap        = tr;
  endtask

  task automatic modelReset();
    for (int k = 1; k <= 4; k++) pipe[k] = 0;
    hold_left     = 0;
    draining      = 1'b0;
    exp_redirect  = 1'b0;
    exp_trap_done = 1'b0;
  endtask

  // One clock of pipeline behaviour, computed from the current inputs.
  task automatic modelStep();
    bit ex_v;
    bit id_v;
    bit lu;
    bit adv;
    bit nr;
    bit nt;
    int exp_ifid;
    int exp_idex;
    ex_v     = (pipe[2] != 0);
    id_v     = (pipe[1] != 0);
    lu       = ex_v && ex_load && (ex_rd != 0) && id_v &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    adv      = 1'b0;
    nr       = 1'b0;
    nt       = 1'b0;
    exp_ifid = 1;
    exp_idex = 1;
    if (draining) begin
      exp_ifid = 0;
      exp_idex = 0;
      if (pipe[3] == 0 && pipe[4] == 0) begin
        draining = 1'b0;
        nt       = 1'b1;
      end
      pipe[4] = pipe[3];
      pipe[3] = 0;
    end else if (ex_v && trap) begin
      exp_ifid  = 0;
      exp_idex  = 0;
      draining  = 1'b1;
      hold_left = 0;
      pipe[4]   = pipe[3];
      pipe[3]   = 0;
      pipe[2]   = 0;
      pipe[1]   = 0;
    end else if (hold_left > 1 || (hold_left == 0 && ex_v && ex_muldiv)) begin
      exp_ifid  = 0;
      exp_idex  = 0;
      hold_left = (hold_left == 0) ? LAT : hold_left - 1;
      pipe[4]   = pipe[3];
      pipe[3]   = 0;
    end else if (hold_left == 1) begin
      hold_left = 0;
      adv       = 1'b1;
    end else if (ex_v && br_taken) begin
      nr      = 1'b1;
      pipe[4] = pipe[3];
      pipe[3] = pipe[2];
      pipe[2] = 0;
      pipe[1] = 0;
    end else if (lu) begin
      exp_ifid = 0;
      pipe[4]  = pipe[3];
      pipe[3]  = pipe[2];
      pipe[2]  = 0;
    end else begin
      adv = 1'b1;
    end
    if (adv) begin
      checkOutput("en_exmem", en_exmem, 1);
      checkOutput("en_memwb", en_memwb, 1);
      pipe[4] = pipe[3];
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      if (fetch_valid) begin
        next_tag++;
        pipe[1] = next_tag;
      end else begin
        pipe[1] = 0;
      end
    end
    checkOutput("en_ifid", en_ifid, exp_ifid);
    checkOutput("en_idex", en_idex, exp_idex);
    exp_redirect  = nr;
    exp_trap_done = nt;
  endtask

  task automatic cycle();
    @(negedge clk);
    checkOutput("v_id", v_id, pipe[1] != 0);
    checkOutput("v_ex", v_ex, pipe[2] != 0);
    checkOutput("v_mem", v_mem, pipe[3] != 0);
    checkOutput("v_wb", v_wb, pipe[4] != 0);
    checkOutput("busy", busy, draining || hold_left > 0);
    checkOutput("redirect", redirect, exp_redirect);
    checkOutput("trap_done", trap_done, exp_trap_done);
    if (!en_ifid) stall_seen++;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  task automatic fetchTwo();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    next_tag = 0;
    rstn     = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_v_id", v_id, 0);
    checkOutput("rst_v_ex", v_ex, 0);
    checkOutput("rst_v_mem", v_mem, 0);
    checkOutput("rst_v_wb", v_wb, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_redirect", redirect, 0);
    checkOutput("rst_trap_done", trap_done, 0);
    checkOutput("rst_en_ifid", en_ifid, 1);
    checkOutput("rst_en_idex", en_idex, 1);
    rstn = 1'b1;

    // Load-use on x5: exactly one stall cycle.
    idle(8);
    fetchTwo();
    stall_seen = 0;
    applyStimulus(1, 5, 1, 1, 1, 5, 1, 0, 0, 0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 5, 1, 1, 1, 5, 0, 0, 0, 0);
      cycle();
    end
    checkOutput("loaduse_stalls", stall_seen, 1);

    // Same pattern targeting x0: no stall.
    idle(8);
    fetchTwo();
    stall_seen = 0;
    applyStimulus(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    checkOutput("x0_stalls", stall_seen, 0);

    // Mul/div: busy for exactly LAT cycles.
    idle(8);
    fetchTwo();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle();
    busy_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_cycles++;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    checkOutput("muldiv_busy_cycles", busy_cycles, LAT);

    // Branch taken coinciding with a load-use match: one redirect, no stall.
    idle(8);
    fetchTwo();
    stall_seen = 0;
    applyStimulus(1, 5, 0, 1, 0, 5, 1, 0, 1, 0);
    cycle();
    redirect_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (redirect) redirect_pulses++;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    checkOutput("branch_redirects", redirect_pulses, 1);
    checkOutput("branch_stalls", stall_seen, 0);

    // Trap with a full pipe: trap_done two cycles after DRAIN entry.
    idle(8);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    entry_at    = -1;
    done_at     = -1;
    done_pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      if (busy && entry_at < 0) entry_at = k;
      if (trap_done) begin
        done_pulses++;
        if (done_at < 0) done_at = k;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    checkOutput("trap_done_latency", done_at - entry_at, 2);
    checkOutput("trap_done_pulses", done_pulses, 1);

    // Trap arriving while a mul/div is holding EX.
    idle(8);
    fetchTwo();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle();
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    idle(8);

    // Asynchronous reset in the middle of a mul/div hold.
    fetchTwo();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    rstn = 1'b0;
    #1;
    checkOutput("async_v_id", v_id, 0);
    checkOutput("async_v_ex", v_ex, 0);
    checkOutput("async_v_mem", v_mem, 0);
    checkOutput("async_v_wb", v_wb, 0);
    checkOutput("async_busy", busy, 0);
    modelReset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    checkOutput("post_reset_v_id", v_id, 1);

    // Random stream against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
